// File: rtl/io_responder.sv
`default_nettype none
// ============================================================================
//  Module   : io_responder
//  Purpose  : Memory-mapped IO target for the single-cycle core. Answers CPU
//             loads/stores with io_addr[15]=1 and holds the sort start/finish
//             state machine, cycle counter, sort count, lamp register,
//             synchronised switch inputs and a 32-entry ASCII display buffer.
//  Ports    : clk, rst_n (sync, active-low)
//             io_addr/io_we/io_re/io_wdata   - CPU access (word index [8:2])
//             io_rdata/io_rvalid             - registered load response
//             btnu_in/cp_in/ch_in            - asynchronous switch pins
//             lamp_out/led_ctrl              - lamp value and lamp source
//             sort_running/sort_done         - FSM status
//             cycle_out/count_out            - cycle counter, sort count
//             disp_idx/disp_char             - display read port (comb.)
//  Revision : 1.0 - initial release
// ============================================================================
module io_responder #(
  parameter int DATA_WIDTH    = 32,
  parameter int IO_ADDR_WIDTH = 7,
  parameter int CYCLE_WIDTH   = 32,
  parameter int LAMP_WIDTH    = 8,
  parameter int DISP_ENTRIES  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [15:0]            io_addr,
  input  logic                   io_we,
  input  logic                   io_re,
  input  logic [DATA_WIDTH-1:0]  io_wdata,
  output logic [DATA_WIDTH-1:0]  io_rdata,
  output logic                   io_rvalid,
  input  logic                   btnu_in,
  input  logic                   cp_in,
  input  logic                   ch_in,
  output logic [LAMP_WIDTH-1:0]  lamp_out,
  output logic                   led_ctrl,
  output logic                   sort_running,
  output logic                   sort_done,
  output logic [CYCLE_WIDTH-1:0] cycle_out,
  output logic [DATA_WIDTH-1:0]  count_out,
  input  logic [4:0]             disp_idx,
  output logic [7:0]             disp_char
);

  localparam int DISP_AW = $clog2(DISP_ENTRIES);

  localparam logic [IO_ADDR_WIDTH-1:0] IDX_DONE      = 'd0;
  localparam logic [IO_ADDR_WIDTH-1:0] IDX_COUNT     = 'd1;
  localparam logic [IO_ADDR_WIDTH-1:0] IDX_LAMP      = 'd2;
  localparam logic [IO_ADDR_WIDTH-1:0] IDX_RUN       = 'd3;
  localparam logic [IO_ADDR_WIDTH-1:0] IDX_BTNU      = 'd4;
  localparam logic [IO_ADDR_WIDTH-1:0] IDX_CP        = 'd5;
  localparam logic [IO_ADDR_WIDTH-1:0] IDX_CH        = 'd6;
  localparam logic [IO_ADDR_WIDTH-1:0] IDX_CYCLE     = 'd7;
  localparam logic [IO_ADDR_WIDTH-1:0] IDX_DISP_BASE = 'd8;
  localparam logic [IO_ADDR_WIDTH-1:0] IDX_DISP_END  = IO_ADDR_WIDTH'(8 + DISP_ENTRIES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                     state;
  logic [2:0]                 sync1;
  logic [2:0]                 sync2;
  logic [7:0]                 disp [DISP_ENTRIES];

  logic [IO_ADDR_WIDTH-1:0]   idx;
  logic                       sel;
  logic                       wr;
  logic                       rd;
  logic                       in_disp;
  logic [DISP_AW-1:0]         disp_sel;
  logic [DATA_WIDTH-1:0]      rd_mux;

  // Address bits outside the decoded fields carry no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, io_addr[14:9], io_addr[1:0]};

  assign sel      = io_addr[15];
  assign idx      = io_addr[IO_ADDR_WIDTH+1:2];
  assign wr       = io_we & sel;
  assign rd       = io_re & sel;
  assign in_disp  = (idx >= IDX_DISP_BASE) && (idx < IDX_DISP_END);
  assign disp_sel = DISP_AW'(idx - IDX_DISP_BASE);

  assign disp_char = disp[disp_idx];

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Read data is taken from current register values, so a store in the
  // same cycle is not visible until the following read.
  always_comb begin
    rd_mux = '0;
    case (idx)
      IDX_DONE:  rd_mux = DATA_WIDTH'(sort_done);
      IDX_COUNT: rd_mux = count_out;
      IDX_LAMP:  rd_mux = DATA_WIDTH'(lamp_out);
      IDX_RUN:   rd_mux = DATA_WIDTH'(sort_running);
      IDX_BTNU:  rd_mux = DATA_WIDTH'(sync2[0]);
      IDX_CP:    rd_mux = DATA_WIDTH'(sync2[1]);
      IDX_CH:    rd_mux = DATA_WIDTH'(sync2[2]);
      IDX_CYCLE: rd_mux = DATA_WIDTH'(cycle_out);
      default:   rd_mux = in_disp ? DATA_WIDTH'(disp[disp_sel]) : '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      sort_running <= 1'b0;
      sort_done    <= 1'b0;
      cycle_out    <= '0;
      count_out    <= '0;
      lamp_out     <= '0;
      led_ctrl     <= 1'b0;
      io_rdata     <= '0;
      io_rvalid    <= 1'b0;
      sync1        <= '0;
      sync2        <= '0;
      for (int i = 0; i < DISP_ENTRIES; i++) begin
        disp[i] <= 8'h20;
      end
    end else begin
      sync1 <= {ch_in, cp_in, btnu_in};
      sync2 <= sync1;

      io_rvalid <= rd;
      if (rd) begin
        io_rdata <= rd_mux;
      end

      // Sort FSM and cycle counter. A start restarts from zero even in RUN;
      // the finish edge itself does not count.
      if (wr && (idx == IDX_RUN)) begin
        state        <= S_RUN;
        sort_running <= 1'b1;
        sort_done    <= 1'b0;
        cycle_out    <= '0;
      end else if (wr && (idx == IDX_DONE) && (state == S_RUN)) begin
        state        <= S_DONE;
        sort_running <= 1'b0;
        sort_done    <= 1'b1;
      end else if ((state == S_RUN) && (cycle_out != '1)) begin
        cycle_out <= cycle_out + CYCLE_WIDTH'(1);
      end

      if (wr && (idx == IDX_COUNT)) begin
        count_out <= io_wdata;
      end

      // Once software writes the lamp, the LEDs stay under its control.
      if (wr && (idx == IDX_LAMP)) begin
        lamp_out <= io_wdata[LAMP_WIDTH-1:0];
        led_ctrl <= 1'b1;
      end

      if (wr && in_disp) begin
        disp[disp_sel] <= hex_ascii(io_wdata[3:0]);
      end
    end
  end

endmodule
`default_nettype wire
